dir_msg_dispatch: RTL and testbench
===================================

Name: dir_msg_dispatch

Overview:
- Downstream stage of the directory FSM (directory/listen side).
- Consumes the directory's 3-bit action code plus requester node ID, and owns the sharers bit-vector for one block.
- Serialises the resulting coherence messages to the per-node cache controllers: invalidate, fetch, fetch/invalidate and data value reply.
- Collects acknowledgements, then updates sharers.

Parameters:
- N_NODES, 4, number of processor nodes; 2..8.
- NODE_W, 2, node ID width; equals clog2(N_NODES).
- TIMEOUT_CYC, 64, ack wait limit in cycles; used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- act_valid  in  1  directory action present.
- act_code  in  3  directory SIGNAL code 0..5.
- act_req  in  NODE_W  requesting node P.
- act_ready  out  1  high only in IDLE.
- msg_valid  out  1  outgoing message valid.
- msg_type  out  3  MSG_DREPLY=1, MSG_FETCH=5, MSG_FETCH_INV=6, MSG_INV=7.
- msg_dest  out  NODE_W  destination node.
- msg_ready  in  1  network accepts message.
- ack_valid  in  1  acknowledgement from a node.
- ack_src  in  NODE_W  acknowledging node.
- sharers  out  N_NODES  current sharers vector.
- done  out  1  one-cycle pulse when an action completes.
- err  out  1  one-cycle pulse on illegal code, missing owner or timeout.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; act_ready=1 in the first cycle after reset.
  - msg_valid=0, msg_type=0, msg_dest=0.
  - sharers=0, done=0, err=0, pending=0.
- Reset asserted mid-operation: abort immediately; any held message is dropped (msg_valid=0 next cycle).
- FSM states: IDLE, SCAN, SEND, WAIT_ACK, REPLY, DONE.
- IDLE: act_valid && act_ready at edge T latches act_code, act_req and snapshot S=sharers, then dispatches by code:
  - 0, reply + sharers|=P: REPLY at T+1.
  - 4, reply + sharers={P}: REPLY at T+1.
  - 3, sharers={}: DONE at T+1, no messages.
  - 2, invalidate + {P} + reply: pending=S & ~(1<<P), then SCAN.
  - 1, fetch: owner=lowest set bit of S; type FETCH.
  - 5, fetch/invalidate: owner as for code 1; type FETCH_INV.
  - Codes 1/5 with S==0, or owner==P: err pulse if S==0; REPLY without fetch.
  - Codes 6/7: err pulse at T+1, DONE, sharers unchanged.
- SCAN (code 2), one cycle:
  - pending==0 goes to REPLY.
  - Otherwise msg_dest=lowest set index, msg_type=MSG_INV, go to SEND.
- SEND:
  - msg_valid=1; msg_type and msg_dest held stable until msg_ready.
  - On handshake, go to WAIT_ACK.
- WAIT_ACK:
  - Wait for ack_valid && ack_src==msg_dest.
  - Ack from any other node is ignored.
  - On match, clear that pending bit and go to SCAN (code 2) or REPLY (codes 1/5).
- REPLY: msg_valid=1, msg_type=MSG_DREPLY, msg_dest=P; on handshake go to DONE.
- DONE:
  - done=1 for one cycle.
  - sharers written once, visible in this cycle: S|(1<<P) for codes 0/1, 1<<P for codes 2/4/5, 0 for code 3.
  - Return to IDLE.
- ack_valid outside WAIT_ACK is ignored.
- An ack arriving in the same cycle as the msg_ready handshake is ignored; only acks from the cycle after are counted.
- Latency, reply-only action with msg_ready=1: accept at T, msg_valid at T+1, done at T+2, act_ready at T+3.
- Each invalidation costs 3 cycles plus ack delay (SCAN, SEND, WAIT_ACK with a minimum 1-cycle ack).

Optional Feature:
- Macro DIR_ACK_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT_ACK.
  - After TIMEOUT_CYC cycles with no matching ack: err pulse; that node is treated as acknowledged and removed from the final sharers; FSM proceeds as on ack.
- When undefined: WAIT_ACK waits indefinitely; no counter is synthesised.

Decomposition:
- Shared package dir_pkg holds:
  - state enum;
  - ACT_* codes 0..5, matching the directory SIGNAL encoding;
  - MSG_* codes 1/5/6/7, matching the cache-side BUS encoding for fetch/fetch-invalidate/invalidate;
  - N_NODES default.
- One sub-module: dir_lowest_set, a combinational priority encoder returning the lowest set index plus a found flag; used for both owner and pending scan.

Test Plan:
- Reset, then act_code=0, act_req=2, msg_ready=1 -> DREPLY to node 2 at T+1; done at T+2; sharers=4'b0100.
- sharers=4'b1011, act_code=2, act_req=0 -> INV to node 1, then node 3, each waiting its ack; then DREPLY to 0; sharers=4'b0001. An ack from node 2 during the wait is ignored.
- sharers=4'b0100, act_code=5, act_req=1 -> FETCH_INV to node 2, ack, DREPLY to 1; sharers=4'b0010. Code 1 gives sharers=4'b0110.
- msg_ready held low 5 cycles in SEND -> msg_valid, msg_type and msg_dest stable throughout; act_ready=0.
- act_code=6 -> err pulse, done pulse, sharers unchanged. act_code=1 with sharers=0 -> err pulse, DREPLY only.
- Reset asserted while in WAIT_ACK -> next cycle IDLE, sharers=0, msg_valid=0. With DIR_ACK_TIMEOUT_EN and no ack -> err pulse after 64 cycles, then the action completes.

Source files
------------

// File: rtl/dir_msg_dispatch_pkg.sv
// Shared encodings for the directory message dispatcher: FSM states,
// directory action codes and cache-side message codes.
package dir_pkg;

  localparam int DIR_N_NODES = 4;

  // Directory SIGNAL encoding
  localparam logic [2:0] ACT_REPLY_ADD  = 3'd0;
  localparam logic [2:0] ACT_FETCH      = 3'd1;
  localparam logic [2:0] ACT_INV_REPLY  = 3'd2;
  localparam logic [2:0] ACT_CLEAR      = 3'd3;
  localparam logic [2:0] ACT_REPLY_EXCL = 3'd4;
  localparam logic [2:0] ACT_FETCH_INV  = 3'd5;

  // Cache-side BUS encoding
  localparam logic [2:0] MSG_NONE      = 3'd0;
  localparam logic [2:0] MSG_DREPLY    = 3'd1;
  localparam logic [2:0] MSG_FETCH     = 3'd5;
  localparam logic [2:0] MSG_FETCH_INV = 3'd6;
  localparam logic [2:0] MSG_INV       = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SEND,
    ST_WAIT_ACK,
    ST_REPLY,
    ST_DONE
  } dir_state_e;

endpackage

// File: rtl/dir_msg_dispatch_lowest_set.sv
// Combinational priority encoder: index of the lowest set bit of vec,
// with found=0 (and idx=0) when vec is all zeros.
module dir_lowest_set #(
  parameter int W     = 4,
  parameter int IDX_W = 2
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scanning from the top lets the lowest set bit win.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dir_msg_dispatch.sv
// Directory-side message dispatcher: turns an action code into INV/FETCH/DREPLY
// messages, collects acks and owns the sharers vector. Optional DIR_ACK_TIMEOUT_EN.
module dir_msg_dispatch
  import dir_pkg::*;
#(
  parameter int N_NODES = DIR_N_NODES,
  parameter int NODE_W  = $clog2(N_NODES)
`ifdef DIR_ACK_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               act_valid,
  input  logic [2:0]         act_code,
  input  logic [NODE_W-1:0]  act_req,
  output logic               act_ready,
  output logic               msg_valid,
  output logic [2:0]         msg_type,
  output logic [NODE_W-1:0]  msg_dest,
  input  logic               msg_ready,
  input  logic               ack_valid,
  input  logic [NODE_W-1:0]  ack_src,
  output logic [N_NODES-1:0] sharers,
  output logic               done,
  output logic               err
);

  dir_state_e          state_q, state_d;
  logic [2:0]          code_q, code_d, msg_type_q, msg_type_d;
  logic [NODE_W-1:0]   req_q, req_d, msg_dest_q, msg_dest_d;
  logic [N_NODES-1:0]  snap_q, snap_d, pending_q, pending_d, sharers_q, sharers_d;
  logic                msg_valid_q, msg_valid_d, done_q, done_d, err_q, err_d;
  logic                act_ready_q, act_ready_d;
  logic [N_NODES-1:0]  scan_vec, act_p_bit, p_bit, dest_bit, drop_mask;
  logic [NODE_W-1:0]   lowest_idx;
  logic                lowest_found, ack_match, ack_timeout;

  assign act_p_bit = N_NODES'(1) << act_req;
  assign p_bit     = N_NODES'(1) << req_q;
  assign dest_bit  = N_NODES'(1) << msg_dest_q;
  assign ack_match = ack_valid && (ack_src == msg_dest_q);
  // In IDLE the encoder finds the owner; elsewhere it walks the pending set.
  assign scan_vec  = (state_q == ST_IDLE) ? sharers_q : pending_q;

  dir_lowest_set #(.W(N_NODES), .IDX_W(NODE_W)) u_lowest (
    .vec   (scan_vec),
    .idx   (lowest_idx),
    .found (lowest_found)
  );

`ifdef DIR_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_NODES-1:0] drop_q, drop_d;
  assign ack_timeout = (state_q == ST_WAIT_ACK) && !ack_match
                       && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign drop_mask   = drop_q;
`else
  assign ack_timeout = 1'b0;
  assign drop_mask   = '0;
`endif

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    req_d       = req_q;
    snap_d      = snap_q;
    pending_d   = pending_q;
    msg_valid_d = msg_valid_q;
    msg_type_d  = msg_type_q;
    msg_dest_d  = msg_dest_q;
    sharers_d   = sharers_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    act_ready_d = 1'b0;
`ifdef DIR_ACK_TIMEOUT_EN
    cnt_d       = cnt_q;
    drop_d      = drop_q;
`endif
    case (state_q)
      ST_IDLE: begin
        act_ready_d = 1'b1;
        if (act_valid) begin
          act_ready_d = 1'b0;
          code_d      = act_code;
          req_d       = act_req;
          snap_d      = sharers_q;
          pending_d   = '0;
`ifdef DIR_ACK_TIMEOUT_EN
          drop_d      = '0;
`endif
          case (act_code)
            ACT_REPLY_ADD, ACT_REPLY_EXCL: begin
              state_d     = ST_REPLY;
              msg_valid_d = 1'b1;
              msg_type_d  = MSG_DREPLY;
              msg_dest_d  = act_req;
            end
            ACT_CLEAR: begin
              state_d   = ST_DONE;
              done_d    = 1'b1;
              sharers_d = '0;
            end
            ACT_INV_REPLY: begin
              state_d   = ST_SCAN;
              pending_d = sharers_q & ~act_p_bit;
            end
            ACT_FETCH, ACT_FETCH_INV: begin
              msg_valid_d = 1'b1;
              // No owner, or the requester already owns it: reply directly.
              if (lowest_found && (lowest_idx != act_req)) begin
                state_d    = ST_SEND;
                msg_type_d = (act_code == ACT_FETCH) ? MSG_FETCH : MSG_FETCH_INV;
                msg_dest_d = lowest_idx;
              end else begin
                state_d    = ST_REPLY;
                err_d      = !lowest_found;
                msg_type_d = MSG_DREPLY;
                msg_dest_d = act_req;
              end
            end
            default: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_SCAN: begin
        msg_valid_d = 1'b1;
        if (lowest_found) begin
          state_d    = ST_SEND;
          msg_type_d = MSG_INV;
          msg_dest_d = lowest_idx;
        end else begin
          state_d    = ST_REPLY;
          msg_type_d = MSG_DREPLY;
          msg_dest_d = req_q;
        end
      end
      ST_SEND: begin
        if (msg_ready) begin
          state_d     = ST_WAIT_ACK;
          msg_valid_d = 1'b0;
`ifdef DIR_ACK_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_WAIT_ACK: begin
`ifdef DIR_ACK_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
        if (ack_timeout) begin
          err_d  = 1'b1;
          drop_d = drop_q | dest_bit;
        end
`endif
        if (ack_match || ack_timeout) begin
          pending_d = pending_q & ~dest_bit;
          if (code_q == ACT_INV_REPLY) begin
            state_d = ST_SCAN;
          end else begin
            state_d     = ST_REPLY;
            msg_valid_d = 1'b1;
            msg_type_d  = MSG_DREPLY;
            msg_dest_d  = req_q;
          end
        end
      end
      ST_REPLY: begin
        if (msg_ready) begin
          state_d     = ST_DONE;
          msg_valid_d = 1'b0;
          done_d      = 1'b1;
          if ((code_q == ACT_REPLY_ADD) || (code_q == ACT_FETCH))
            sharers_d = (snap_q | p_bit) & ~drop_mask;
          else
            sharers_d = p_bit;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        act_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        act_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      req_q       <= '0;
      snap_q      <= '0;
      pending_q   <= '0;
      msg_valid_q <= 1'b0;
      msg_type_q  <= MSG_NONE;
      msg_dest_q  <= '0;
      sharers_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      act_ready_q <= 1'b1;
`ifdef DIR_ACK_TIMEOUT_EN
      cnt_q       <= '0;
      drop_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      req_q       <= req_d;
      snap_q      <= snap_d;
      pending_q   <= pending_d;
      msg_valid_q <= msg_valid_d;
      msg_type_q  <= msg_type_d;
      msg_dest_q  <= msg_dest_d;
      sharers_q   <= sharers_d;
      done_q      <= done_d;
      err_q       <= err_d;
      act_ready_q <= act_ready_d;
`ifdef DIR_ACK_TIMEOUT_EN
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
`endif
    end
  end

  assign act_ready = act_ready_q;
  assign msg_valid = msg_valid_q;
  assign msg_type  = msg_type_q;
  assign msg_dest  = msg_dest_q;
  assign sharers   = sharers_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dir_msg_dispatch.sv
// Directed self-checking bench for dir_msg_dispatch; the timeout scenario
// runs only when DIR_ACK_TIMEOUT_EN is defined.
module tb_dir_msg_dispatch;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       act_valid = 1'b0;
  logic [2:0] act_code = 3'd0;
  logic [1:0] act_req = 2'd0;
  logic       act_ready;
  logic       msg_valid;
  logic [2:0] msg_type;
  logic [1:0] msg_dest;
  logic       msg_ready = 1'b1;
  logic       ack_valid = 1'b0;
  logic [1:0] ack_src = 2'd0;
  logic [3:0] sharers;
  logic       done;
  logic       err;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  dir_msg_dispatch #(.N_NODES(4), .NODE_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .act_valid (act_valid),
    .act_code  (act_code),
    .act_req   (act_req),
    .act_ready (act_ready),
    .msg_valid (msg_valid),
    .msg_type  (msg_type),
    .msg_dest  (msg_dest),
    .msg_ready (msg_ready),
    .ack_valid (ack_valid),
    .ack_src   (ack_src),
    .sharers   (sharers),
    .done      (done),
    .err       (err)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] code, input logic [1:0] req);
    act_valid = 1'b1;
    act_code  = code;
    act_req   = req;
    step();
    act_valid = 1'b0;
  endtask

  task automatic run_action(input logic [2:0] code, input logic [1:0] req);
    int n;
    n = 0;
    issue(code, req);
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (done !== 1'b1) begin bad++; $display("[TB] FAIL run_action_done code=%0d got=%0b exp=1", code, done); end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++;
    if ({act_ready, msg_valid, msg_type, msg_dest, sharers, done, err} !== {1'b1, 1'b0, 3'd0, 2'd0, 4'b0000, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_state got=%b exp=%b", {act_ready, msg_valid, msg_type, msg_dest, sharers, done, err},
               {1'b1, 1'b0, 3'd0, 2'd0, 4'b0000, 1'b0, 1'b0});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_reply_add();
    issue(3'd0, 2'd2);
    total++;
    if ({msg_valid, msg_type, msg_dest, act_ready} !== {1'b1, 3'd1, 2'd2, 1'b0}) begin
      bad++; $display("[TB] FAIL reply_msg got=%b exp=%b", {msg_valid, msg_type, msg_dest, act_ready}, {1'b1, 3'd1, 2'd2, 1'b0});
    end
    step();
    total++;
    if ({done, msg_valid, sharers} !== {1'b1, 1'b0, 4'b0100}) begin
      bad++; $display("[TB] FAIL reply_done got=%b exp=%b", {done, msg_valid, sharers}, {1'b1, 1'b0, 4'b0100});
    end
    step();
    total++;
    if ({act_ready, done} !== 2'b10) begin
      bad++; $display("[TB] FAIL reply_idle got=%b exp=10", {act_ready, done});
    end
  endtask

  task automatic test_invalidate();
    run_action(3'd3, 2'd0);
    run_action(3'd4, 2'd0);
    run_action(3'd0, 2'd1);
    run_action(3'd0, 2'd3);
    total++;
    if (sharers !== 4'b1011) begin bad++; $display("[TB] FAIL inv_preload got=%b exp=1011", sharers); end
    issue(3'd2, 2'd0);
    total++;
    if ({msg_valid, act_ready, done} !== 3'b000) begin
      bad++; $display("[TB] FAIL inv_scan got=%b exp=000", {msg_valid, act_ready, done});
    end
    step();
    total++;
    if ({msg_valid, msg_type, msg_dest} !== {1'b1, 3'd7, 2'd1}) begin
      bad++; $display("[TB] FAIL inv_send1 got=%b exp=%b", {msg_valid, msg_type, msg_dest}, {1'b1, 3'd7, 2'd1});
    end
    step();
    ack_valid = 1'b1;
    ack_src   = 2'd2;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({msg_valid, done} !== 2'b00) begin bad++; $display("[TB] FAIL inv_wrong_ack got=%b exp=00", {msg_valid, done}); end
    end
    ack_src = 2'd1;
    step();
    ack_valid = 1'b0;
    step();
    total++;
    if ({msg_valid, msg_type, msg_dest} !== {1'b1, 3'd7, 2'd3}) begin
      bad++; $display("[TB] FAIL inv_send3 got=%b exp=%b", {msg_valid, msg_type, msg_dest}, {1'b1, 3'd7, 2'd3});
    end
    // Ack raised during the handshake cycle must not count.
    ack_valid = 1'b1;
    ack_src   = 2'd3;
    step();
    ack_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({msg_valid, done} !== 2'b00) begin bad++; $display("[TB] FAIL inv_early_ack got=%b exp=00", {msg_valid, done}); end
    end
    ack_valid = 1'b1;
    step();
    ack_valid = 1'b0;
    step();
    total++;
    if ({msg_valid, msg_type, msg_dest} !== {1'b1, 3'd1, 2'd0}) begin
      bad++; $display("[TB] FAIL inv_reply got=%b exp=%b", {msg_valid, msg_type, msg_dest}, {1'b1, 3'd1, 2'd0});
    end
    step();
    total++;
    if ({done, sharers} !== {1'b1, 4'b0001}) begin
      bad++; $display("[TB] FAIL inv_done got=%b exp=%b", {done, sharers}, {1'b1, 4'b0001});
    end
    step();
  endtask

  task automatic test_fetch(input logic [2:0] code, input logic [2:0] exp_type, input logic [3:0] exp_sharers);
    run_action(3'd4, 2'd2);
    issue(code, 2'd1);
    total++;
    if ({msg_valid, msg_type, msg_dest} !== {1'b1, exp_type, 2'd2}) begin
      bad++; $display("[TB] FAIL fetch_send code=%0d got=%b exp=%b", code, {msg_valid, msg_type, msg_dest}, {1'b1, exp_type, 2'd2});
    end
    step();
    ack_valid = 1'b1;
    ack_src   = 2'd2;
    step();
    ack_valid = 1'b0;
    total++;
    if ({msg_valid, msg_type, msg_dest} !== {1'b1, 3'd1, 2'd1}) begin
      bad++; $display("[TB] FAIL fetch_reply code=%0d got=%b exp=%b", code, {msg_valid, msg_type, msg_dest}, {1'b1, 3'd1, 2'd1});
    end
    step();
    total++;
    if ({done, sharers} !== {1'b1, exp_sharers}) begin
      bad++; $display("[TB] FAIL fetch_done code=%0d got=%b exp=%b", code, {done, sharers}, {1'b1, exp_sharers});
    end
    step();
  endtask

  task automatic test_stall();
    msg_ready = 1'b0;
    issue(3'd1, 2'd3);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({msg_valid, msg_type, msg_dest, act_ready} !== {1'b1, 3'd5, 2'd1, 1'b0}) begin
        bad++; $display("[TB] FAIL stall_hold cyc=%0d got=%b exp=%b", i, {msg_valid, msg_type, msg_dest, act_ready}, {1'b1, 3'd5, 2'd1, 1'b0});
      end
      step();
    end
    msg_ready = 1'b1;
    step();
    total++;
    if (msg_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_release got=%b exp=0", msg_valid); end
    ack_valid = 1'b1;
    ack_src   = 2'd1;
    step();
    ack_valid = 1'b0;
    step();
    total++;
    if ({done, sharers} !== {1'b1, 4'b1110}) begin
      bad++; $display("[TB] FAIL stall_done got=%b exp=%b", {done, sharers}, {1'b1, 4'b1110});
    end
    step();
  endtask

  task automatic test_illegal();
    issue(3'd6, 2'd0);
    total++;
    if ({err, done, msg_valid, sharers} !== {1'b1, 1'b1, 1'b0, 4'b1110}) begin
      bad++; $display("[TB] FAIL illegal_code got=%b exp=%b", {err, done, msg_valid, sharers}, {1'b1, 1'b1, 1'b0, 4'b1110});
    end
    step();
    total++;
    if ({err, done, act_ready} !== 3'b001) begin bad++; $display("[TB] FAIL illegal_after got=%b exp=001", {err, done, act_ready}); end
    run_action(3'd3, 2'd0);
    total++;
    if (sharers !== 4'b0000) begin bad++; $display("[TB] FAIL clear_sharers got=%b exp=0000", sharers); end
    issue(3'd1, 2'd2);
    total++;
    if ({err, msg_valid, msg_type, msg_dest} !== {1'b1, 1'b1, 3'd1, 2'd2}) begin
      bad++; $display("[TB] FAIL no_owner got=%b exp=%b", {err, msg_valid, msg_type, msg_dest}, {1'b1, 1'b1, 3'd1, 2'd2});
    end
    step();
    total++;
    if ({done, err, sharers} !== {1'b1, 1'b0, 4'b0100}) begin
      bad++; $display("[TB] FAIL no_owner_done got=%b exp=%b", {done, err, sharers}, {1'b1, 1'b0, 4'b0100});
    end
    step();
  endtask

  task automatic test_reset_mid();
    msg_ready = 1'b0;
    issue(3'd2, 2'd0);
    step();
    reset = 1'b1;
    step();
    total++;
    if ({act_ready, msg_valid, sharers} !== {1'b1, 1'b0, 4'b0000}) begin
      bad++; $display("[TB] FAIL reset_send got=%b exp=%b", {act_ready, msg_valid, sharers}, {1'b1, 1'b0, 4'b0000});
    end
    reset = 1'b0;
    msg_ready = 1'b1;
    step();
    run_action(3'd4, 2'd2);
    issue(3'd2, 2'd0);
    step();
    step();
    reset = 1'b1;
    step();
    total++;
    if ({act_ready, msg_valid, sharers, done} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
      bad++; $display("[TB] FAIL reset_wait got=%b exp=%b", {act_ready, msg_valid, sharers, done}, {1'b1, 1'b0, 4'b0000, 1'b0});
    end
    reset = 1'b0;
    step();
  endtask

`ifdef DIR_ACK_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    run_action(3'd4, 2'd2);
    issue(3'd2, 2'd0);
    step();
    step();
    n = 0;
    while (err !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    total++;
    if (n != 64) begin bad++; $display("[TB] FAIL timeout_cycles got=%0d exp=64", n); end
    step();
    step();
    total++;
    if ({done, sharers} !== {1'b1, 4'b0001}) begin
      bad++; $display("[TB] FAIL timeout_done got=%b exp=%b", {done, sharers}, {1'b1, 4'b0001});
    end
    step();
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_reply_add();
    test_invalidate();
    test_fetch(3'd5, 3'd6, 4'b0010);
    test_fetch(3'd1, 3'd5, 4'b0110);
    test_stall();
    test_illegal();
    test_reset_mid();
`ifdef DIR_ACK_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
